rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 143 ++++++++++++++
 tb/tb_rr_arbiter4.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter feeding a one-entry output register.
// The requester at ptr has highest priority; after each grant ptr moves to the
// index just past the winner, so every valid requester is served within 4 grants.
module rr_arbiter4 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [1:0]   ptr_r;
    logic [N-1:0] out_data_r;
    logic [1:0]   out_sel_r;

    logic [7:0]   req_dbl_s;
    logic [3:0]   req_rot_s;
    logic [1:0]   offset_s;
    logic         found_s;
    logic [1:0]   win_s;
    logic         load_en_s;
    logic         transfer_s;
    logic [N-1:0] win_data_s;
    logic [3:0]   req_ready_s;

    // Rotate requests so that bit 0 is the requester at ptr (highest priority).
    assign req_dbl_s = {req_valid, req_valid};
    assign req_rot_s = req_dbl_s[ptr_r +: 4];

    // Priority-encode the rotated request vector: first set bit wins.
    always_comb begin
        found_s  = 1'b1;
        offset_s = 2'd0;
        if (req_rot_s[0]) begin
            offset_s = 2'd0;
        end else if (req_rot_s[1]) begin
            offset_s = 2'd1;
        end else if (req_rot_s[2]) begin
            offset_s = 2'd2;
        end else if (req_rot_s[3]) begin
            offset_s = 2'd3;
        end else begin
            found_s  = 1'b0;
            offset_s = 2'd0;
        end
    end

    // Map the rotated offset back to an absolute requester index (wraps mod 4).
    assign win_s      = ptr_r + offset_s;
    assign load_en_s  = (state_r == ST_EMPTY) | out_ready;
    assign transfer_s = found_s & load_en_s;

    // Decode the grant: one-hot on the winner when the register can load, else zero.
    always_comb begin
        req_ready_s = 4'b0000;
        if (transfer_s) begin
            case (win_s)
                2'd0:    req_ready_s = 4'b0001;
                2'd1:    req_ready_s = 4'b0010;
                2'd2:    req_ready_s = 4'b0100;
                2'd3:    req_ready_s = 4'b1000;
                default: req_ready_s = 4'b0000;
            endcase
        end else begin
            req_ready_s = 4'b0000;
        end
    end

    // Select the winning requester's data word.
    always_comb begin
        win_data_s = in0;
        case (win_s)
            2'd0:    win_data_s = in0;
            2'd1:    win_data_s = in1;
            2'd2:    win_data_s = in2;
            2'd3:    win_data_s = in3;
            default: win_data_s = in0;
        endcase
    end

    // Output-register occupancy: a load keeps or makes it FULL, a bare drain empties it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (transfer_s) begin
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (transfer_s) begin
                    state_s = ST_FULL;
                end else if (out_ready) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // State, pointer and output word; reset wins over any concurrent transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_EMPTY;
            ptr_r      <= 2'd0;
            out_data_r <= {N{1'b0}};
            out_sel_r  <= 2'd0;
        end else begin
            state_r <= state_s;
            if (transfer_s) begin
                out_data_r <= win_data_s;
                out_sel_r  <= win_s;
                ptr_r      <= win_s + 2'd1;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign out_valid = (state_r == ST_FULL);
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 followed by a short randomized run checked
// against an independent behavioural model of the arbiter.
module tb_rr_arbiter4;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] in_w [4];
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int n_compared;
    int n_mismatched;

    rr_arbiter4 #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .in0       (in_w[0]),
        .in1       (in_w[1]),
        .in2       (in_w[2]),
        .in3       (in_w[3]),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered outputs in one go.
    task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
        check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        check_val({tag, "_data"},  out_data, d);
        check_val({tag, "_sel"},   {30'd0, out_sel}, {30'd0, s});
    endtask

    // Random-phase model state.
    logic [3:0]  pend;
    logic [31:0] pdata [4];
    logic        m_valid;
    logic [31:0] m_data;
    logic [1:0]  m_sel;
    logic [1:0]  m_ptr;
    int          waits [4];
    int          max_wait;
    int          n_grants;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_w[i] = 32'h1000_0000 + 32'(i);

        // Reset state.
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 2'd0);
        check_val("reset_rdy", {28'd0, req_ready}, 32'h0);
        rst = 1'b1;

        // All four requesting with out_ready high: 0,1,2,3,0,1,2,3 back to back.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check_val("rr_rdy_first", {28'd0, req_ready}, 32'h1);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_out("rr", 1'b1, 32'h1000_0000 + 32'(c % 4), 2'(c % 4));
            check_val("rr_rdy", {28'd0, req_ready}, 32'h1 << ((c + 1) % 4));
        end

        // Drain with no requests: output empties, word and sel retained, ptr stays 0.
        req_valid = 4'b0000;
        #1;
        check_val("drain_rdy", {28'd0, req_ready}, 32'h0);
        tick();
        check_out("drain", 1'b0, 32'h1000_0003, 2'd3);
        req_valid = 4'b1111;
        #1;
        check_val("drain_ptr0", {28'd0, req_ready}, 32'h1);

        // Single requester 2 with downstream stalled: one accept, then hold.
        req_valid = 4'b0100;
        in_w[2]   = 32'hA5A5_A5A5;
        out_ready = 1'b0;
        #1;
        check_val("stall_rdy_accept", {28'd0, req_ready}, 32'h4);
        tick();
        for (int c = 0; c < 5; c++) begin
            check_out("stall", 1'b1, 32'hA5A5_A5A5, 2'd2);
            check_val("stall_rdy", {28'd0, req_ready}, 32'h0);
            tick();
        end

        // Grant to 3 wraps ptr to 0; then 1001 goes to 0 and ptr becomes 1.
        req_valid = 4'b1000;
        out_ready = 1'b1;
        #1;
        check_val("wrap_rdy3", {28'd0, req_ready}, 32'h8);
        tick();
        check_out("wrap_g3", 1'b1, 32'h1000_0003, 2'd3);
        req_valid = 4'b1001;
        #1;
        check_val("wrap_rdy0", {28'd0, req_ready}, 32'h1);
        tick();
        check_out("wrap_g0", 1'b1, 32'h1000_0000, 2'd0);
        check_val("wrap_ptr1", {28'd0, req_ready}, 32'h8);

        // Reset while FULL with a concurrent transfer: word dropped, ptr back to 0.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        rst       = 1'b0;
        tick();
        check_out("rst_full", 1'b0, 32'h0, 2'd0);
        rst = 1'b1;
        #1;
        check_val("rst_rdy", {28'd0, req_ready}, 32'h1);
        tick();
        check_out("rst_grant", 1'b1, 32'h1000_0000, 2'd0);

        // Randomized traffic against a behavioural model; requesters hold until accepted.
        m_valid  = 1'b1;
        m_data   = 32'h1000_0000;
        m_sel    = 2'd0;
        m_ptr    = 2'd1;
        pend     = 4'b0000;
        max_wait = 0;
        n_grants = 0;
        for (int i = 0; i < 4; i++) begin
            waits[i] = 0;
            pdata[i] = 32'h0;
        end
        for (int c = 0; c < 3000; c++) begin
            logic       load;
            logic       found;
            logic [1:0] g;
            logic [3:0] exp_rdy;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end
                in_w[i] = pdata[i];
            end
            req_valid = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            load  = !m_valid || out_ready;
            found = 1'b0;
            g     = 2'd0;
            for (int k = 0; k < 4; k++) begin
                if (!found && pend[(int'(m_ptr) + k) % 4]) begin
                    found = 1'b1;
                    g     = 2'((int'(m_ptr) + k) % 4);
                end
            end
            exp_rdy = (found && load) ? (4'b0001 << g) : 4'b0000;
            check_val("rnd_rdy", {28'd0, req_ready}, {28'd0, exp_rdy});
            if ($countones(req_ready) > 1) begin
                check_val("rnd_onehot", 32'($countones(req_ready)), 32'd1);
            end
            if (found && load) begin
                for (int i = 0; i < 4; i++) begin
                    if (i != int'(g) && pend[i]) begin
                        waits[i]++;
                        if (waits[i] > max_wait) max_wait = waits[i];
                    end
                end
                waits[g] = 0;
                m_data  = pdata[g];
                m_sel   = g;
                m_valid = 1'b1;
                m_ptr   = g + 2'd1;
                pend[g] = 1'b0;
                n_grants++;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            check_out("rnd", m_valid, m_data, m_sel);
        end
        check_val("rnd_max_wait_ok", {31'd0, (max_wait <= 3)}, 32'd1);
        check_val("rnd_some_grants", {31'd0, (n_grants > 1000)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
